// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: result = a - b, LSB first, one bit per clock,
// with one full-subtractor cell and a registered borrow. The start/done handshake
// gives a latency of WIDTH+1 cycles per operation.
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] result,
    output logic             borrow_out,
    output logic             busy,
    output logic             done,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               busy_d;
    logic               done_d;

    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-2:0]   diff_sr;
    logic               brw_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               accept;
    logic               last_bit;
    logic               d_bit;
    logic               brw_d;

    // A new operation is accepted in any state except SHIFT.
    assign accept   = start && (state_q != S_SHIFT);
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // Single full-subtractor cell operating on the current LSBs.
    always_comb begin
        d_bit = a_sr[0] ^ b_sr[0] ^ brw_q;
        brw_d = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw_q);
    end

    // State register; busy/done are registered from the next-state decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_SHIFT;
            S_SHIFT: if (last_bit) state_d = S_DONE;
            S_DONE:  state_d = start ? S_SHIFT : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode of the upcoming state, so the flopped outputs line up with it.
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        busy_d = (state_d == S_SHIFT);
        done_d = (state_d == S_DONE);
    end

    // Operand capture, serial shifting and result update on the final bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr       <= '0;
            b_sr       <= '0;
            diff_sr    <= '0;
            brw_q      <= 1'b0;
            cnt_q      <= '0;
            result     <= '0;
            borrow_out <= 1'b0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= b;
            brw_q <= 1'b0;
            cnt_q <= '0;
        end else if (state_q == S_SHIFT) begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            diff_sr <= (WIDTH-1)'({d_bit, diff_sr} >> 1);
            brw_q   <= brw_d;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (last_bit) begin
                result     <= {d_bit, diff_sr};
                borrow_out <= brw_d;
            end
        end
    end

endmodule
